// File: rtl/bpu_pkg.sv
// Shared gshare/bimodal predictor helpers: counter reset value, saturating
// counter step and the PC/history index hash.
`default_nettype none

package bpu_pkg;

  localparam int CNT_W_MAX = 4;

  // Weakly-taken value: only the MSB of a cnt_w-bit counter set.
  function automatic logic [CNT_W_MAX-1:0] cnt_reset_val(input int cnt_w);
    return 4'(1 << (cnt_w - 1));
  endfunction

  function automatic logic [CNT_W_MAX-1:0] cnt_sat_step(
    input logic [CNT_W_MAX-1:0] cnt,
    input logic                 taken,
    input int                   cnt_w
  );
    logic [CNT_W_MAX-1:0] cnt_max;
    cnt_max = 4'((1 << cnt_w) - 1);
    if (taken) begin
      return (cnt == cnt_max) ? cnt : cnt + 4'd1;
    end
    return (cnt == 4'd0) ? cnt : cnt - 4'd1;
  endfunction

  function automatic logic [31:0] idx_hash(
    input logic [31:0] pc_bits,
    input logic [31:0] ghr
  );
    return pc_bits ^ ghr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bpu_pht.sv
// Pattern history table: array of saturating counters with one registered
// read port and one write (update) port; read returns the pre-write value.
`default_nettype none

module bpu_pht
  import bpu_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [CNT_W-1:0] rd_cnt_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(cnt_reset_val(CNT_W));

  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] rd_cnt_q;
  logic [CNT_W-1:0] wr_cnt_d;

  always_comb begin
    wr_cnt_d = CNT_W'(cnt_sat_step(4'(cnt_q[wr_idx_i]), wr_taken_i, CNT_W));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= CNT_RST;
      end
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= wr_cnt_d;
    end
  end

  // Read register only loads on a lookup so the output holds between requests.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt_q <= '0;
    end else if (rd_en_i) begin
      rd_cnt_q <= cnt_q[rd_idx_i];
    end
  end

  assign rd_cnt_o = rd_cnt_q;

endmodule

`default_nettype wire

// File: rtl/bpu_gshare.sv
// Branch direction predictor: gshare when BPU_GSHARE_EN is defined (PC xor
// global history), plain bimodal PC indexing otherwise.
`default_nettype none

module bpu_gshare
  import bpu_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int IDX_W  = 6,
  parameter int CNT_W  = 2,
  parameter int HIST_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pred_valid_i,
  input  logic [PC_W-1:0]  pred_pc_i,
  output logic             pred_valid_o,
  output logic             pred_taken_o,
  output logic [IDX_W-1:0] pred_idx_o,
  input  logic             upd_valid_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  logic [IDX_W-1:0] lookup_idx;
  logic [CNT_W-1:0] rd_cnt;
  logic             valid_q;
  logic [IDX_W-1:0] idx_q;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{pred_pc_i[PC_W-1:IDX_W+2], pred_pc_i[1:0]};

`ifdef BPU_GSHARE_EN
  logic [HIST_W-1:0] ghr_q;
  logic [HIST_W-1:0] ghr_d;

  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid_i) begin
      ghr_d = HIST_W'({ghr_q, upd_taken_i});
    end
  end

  // Non-speculative history: only resolved updates shift it in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign lookup_idx = IDX_W'(idx_hash(32'(pred_pc_i[IDX_W+1:2]), 32'(ghr_q)));
`else
  assign lookup_idx = pred_pc_i[IDX_W+1:2];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      valid_q <= pred_valid_i;
      if (pred_valid_i) begin
        idx_q <= lookup_idx;
      end
    end
  end

  bpu_pht #(
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_pht (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_en_i    (pred_valid_i),
    .rd_idx_i   (lookup_idx),
    .rd_cnt_o   (rd_cnt),
    .wr_en_i    (upd_valid_i),
    .wr_idx_i   (upd_idx_i),
    .wr_taken_i (upd_taken_i)
  );

  assign pred_valid_o = valid_q;
  assign pred_taken_o = rd_cnt[CNT_W-1];
  assign pred_idx_o   = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_bpu_gshare.sv
// Directed and randomized checks of bpu_gshare against a table-of-counters
// reference model (IDX_W=6, CNT_W=2, HIST_W=6).
`default_nettype none

module tb_bpu_gshare;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pred_valid_i = 1'b0;
  logic [31:0] pred_pc_i = '0;
  logic        pred_valid_o;
  logic        pred_taken_o;
  logic [5:0]  pred_idx_o;
  logic        upd_valid_i = 1'b0;
  logic [5:0]  upd_idx_i = '0;
  logic        upd_taken_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef BPU_GSHARE_EN
  localparam bit GS = 1'b1;
`else
  localparam bit GS = 1'b0;
`endif

  // Reference model: counters 0..3 and a 6-bit history as plain integers.
  int m_cnt [64];
  int m_ghr;
  int e_valid, e_taken, e_idx;

  always #5 clk = ~clk;

  bpu_gshare dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pred_valid_i (pred_valid_i),
    .pred_pc_i    (pred_pc_i),
    .pred_valid_o (pred_valid_o),
    .pred_taken_o (pred_taken_o),
    .pred_idx_o   (pred_idx_o),
    .upd_valid_i  (upd_valid_i),
    .upd_idx_i    (upd_idx_i),
    .upd_taken_i  (upd_taken_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_valid"}, 32'(pred_valid_o), 32'(e_valid));
    chk({tag, "_taken"}, 32'(pred_taken_o), 32'(e_taken));
    chk({tag, "_idx"},   32'(pred_idx_o),   32'(e_idx));
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) m_cnt[i] = 2;
    m_ghr   = 0;
    e_valid = 0;
    e_taken = 0;
    e_idx   = 0;
  endfunction

  // One clock of stimulus; model predicts from pre-update state, then updates.
  task automatic cycle(input string tag, input bit pv, input logic [31:0] pc,
                       input bit uv, input int ui, input bit ut);
    pred_valid_i = pv;
    pred_pc_i    = pc;
    upd_valid_i  = uv;
    upd_idx_i    = 6'(ui);
    upd_taken_i  = ut;
    e_valid = pv;
    if (pv) begin
      e_idx   = ((pc >> 2) % 64) ^ (GS ? m_ghr : 0);
      e_taken = (m_cnt[e_idx] >= 2) ? 1 : 0;
    end
    if (uv) begin
      if (ut) m_cnt[ui] = (m_cnt[ui] < 3) ? m_cnt[ui] + 1 : 3;
      else    m_cnt[ui] = (m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0;
      m_ghr = (m_ghr * 2 + (ut ? 1 : 0)) % 64;
    end
    @(posedge clk);
    #1;
    chk_outputs(tag);
  endtask

  task automatic idle();
    pred_valid_i = 1'b0;
    upd_valid_i  = 1'b0;
  endtask

  // Reset asserted between edges, checked before any clock, held over one
  // edge with live requests, released on a falling edge.
  task automatic pulse_reset(input string tag);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk_outputs({tag, "_async"});
    pred_valid_i = 1'b1;
    pred_pc_i    = 32'h0000_00fc;
    upd_valid_i  = 1'b1;
    upd_idx_i    = 6'd0;
    upd_taken_i  = 1'b1;
    @(posedge clk);
    #1;
    chk_outputs({tag, "_held"});
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_outputs({tag, "_rel"});
  endtask

  initial begin
    int pc7;
    int last_idx;
    model_reset();
    #2;
    chk_outputs("por");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset lookup of 0x100 sees weakly-taken counter 0.
    cycle("r029", 1, 32'h100, 0, 0, 0);
    chk("r029_const_taken", 32'(pred_taken_o), 32'd1);
    chk("r029_const_idx",   32'(pred_idx_o),   32'd0);
    cycle("r029_idle", 0, 32'h0, 0, 0, 0);

    // Saturation at zero.
    for (int k = 0; k < 3; k++) cycle("r030_upd", 0, 32'h0, 1, 5, 0);
    cycle("r030_look", 1, 32'h14, 0, 0, 0);
    chk("r030_const_taken", 32'(pred_taken_o), 32'd0);
    chk("r030_const_idx",   32'(pred_idx_o),   32'd5);

    // Saturation at max, then a single step back stays taken.
    for (int k = 0; k < 4; k++) cycle("r031_upd", 0, 32'h0, 1, 7, 1);
    chk("r031_model_sat", 32'(m_cnt[7]), 32'd3);
    cycle("r031_nt", 0, 32'h0, 1, 7, 0);
    pc7 = ((7 ^ (GS ? m_ghr : 0)) % 64) * 4;
    cycle("r031_look", 1, 32'(pc7), 0, 0, 0);
    chk("r031_const_taken", 32'(pred_taken_o), 32'd1);
    chk("r031_const_idx",   32'(pred_idx_o),   32'd7);
    cycle("r031_hold", 0, 32'hfff0, 0, 0, 0);

    // History hashing.
    pulse_reset("r032_rst");
    cycle("r032_t1", 0, 32'h0, 1, 10, 1);
    cycle("r032_t2", 0, 32'h0, 1, 10, 1);
    cycle("r032_look", 1, 32'h100, 0, 0, 0);
    chk("r032_const_idx", 32'(pred_idx_o), GS ? 32'd3 : 32'd0);

    // Same-cycle lookup/update on one index returns the old counter.
    pulse_reset("r033_rst");
    cycle("r033_same", 1, 32'h100, 1, 0, 0);
    chk("r033_const_taken0", 32'(pred_taken_o), 32'd1);
    cycle("r033_next", 1, 32'h100, 0, 0, 0);
    chk("r033_const_taken1", 32'(pred_taken_o), 32'd0);

    // Reset in the middle of back-to-back updates.
    cycle("r034_a", 0, 32'h0, 1, 3, 0);
    cycle("r034_b", 1, 32'h0c, 1, 3, 0);
    cycle("r034_c", 1, 32'h1c, 1, 3, 1);
    pulse_reset("r034_rst");
    for (int i = 0; i < 64; i++) begin
      cycle("r034_scan", 1, 32'(i * 4), 0, 0, 0);
      chk("r034_cnt_taken", 32'(pred_taken_o), 32'd1);
    end
    cycle("r034_nt", 0, 32'h0, 1, 3, 0);
    cycle("r034_look", 1, 32'(((3 ^ (GS ? m_ghr : 0)) % 64) * 4), 0, 0, 0);
    chk("r034_const_taken", 32'(pred_taken_o), 32'd0);

    // Randomized traffic with frequent index collisions.
    last_idx = 0;
    for (int n = 0; n < 600; n++) begin
      bit pv, uv, ut;
      int ui;
      logic [31:0] pc;
      if (n == 300) pulse_reset("rnd_rst");
      pv = ($urandom_range(0, 3) != 0);
      uv = ($urandom_range(0, 2) != 0);
      ut = $urandom_range(0, 1);
      pc = $urandom;
      ui = ($urandom_range(0, 3) == 0) ? last_idx : $urandom_range(0, 63);
      cycle("rnd", pv, pc, uv, ui, ut);
      if (pv) last_idx = e_idx;
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
